wb_port_arbiter: RTL and testbench

- Shares the single register-file write port between the in-order writeback stage and an out-of-order multi-cycle unit (divider / long-latency load return).
- Pipeline writes have priority.
- Multi-cycle results are queued in a small FIFO and drained into idle writeback slots.
- A starvation counter requests a pipeline bubble, and a scoreboard lookup lets the hazard unit stall readers of queued destinations.

---
 rtl/wb_port_arbiter.sv | 143 ++++++++++++++
 tb/tb_wb_port_arbiter.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter: in-order writeback has priority, multi-cycle results queue in
// a small FIFO and drain into idle slots. Optional macro WB_BYPASS_EN lets mc results skip an empty FIFO.
module wb_port_arbiter #(
  parameter int unsigned XLEN         = 32,
  parameter int unsigned DEPTH        = 4,
  parameter int unsigned STARVE_LIMIT = 8
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            pipe_we_i,
  input  logic [4:0]      pipe_rd_i,
  input  logic [XLEN-1:0] pipe_data_i,
  input  logic            mc_valid_i,
  output logic            mc_ready_o,
  input  logic [4:0]      mc_rd_i,
  input  logic [XLEN-1:0] mc_data_i,
  output logic            rf_we_o,
  output logic [4:0]      rf_rd_o,
  output logic [XLEN-1:0] rf_wd_o,
  output logic            stall_req_o,
  input  logic [4:0]      chk_rd_i,
  output logic            chk_hit_o
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;
  localparam int unsigned StW  = $clog2(STARVE_LIMIT + 1);
  localparam logic [CntW-1:0] Full    = CntW'(DEPTH);
  localparam logic [StW-1:0]  StLimit = StW'(STARVE_LIMIT);

  logic [4:0]      rd_mem_q   [DEPTH];
  logic [XLEN-1:0] data_mem_q [DEPTH];

  logic [PtrW-1:0] head_q, head_d, tail_q, tail_d;
  logic [CntW-1:0] count_q, count_d;
  logic [StW-1:0]  starve_q, starve_d;
  logic            rf_we_q, rf_we_d;
  logic [4:0]      rf_rd_q, rf_rd_d;
  logic [XLEN-1:0] rf_wd_q, rf_wd_d;

  logic pipe_req, not_full, not_empty, xfer, bypass, push, pop;

  always_comb begin
    pipe_req  = pipe_we_i && (pipe_rd_i != 5'd0);
    not_full  = (count_q != Full);
    not_empty = (count_q != '0);
    xfer      = mc_valid_i && not_full;
    pop       = !pipe_req && not_empty;
`ifdef WB_BYPASS_EN
    bypass    = xfer && !pipe_req && !not_empty && (mc_rd_i != 5'd0);
`else
    bypass    = 1'b0;
`endif
    // rd=0 results are accepted but dropped.
    push      = xfer && (mc_rd_i != 5'd0) && !bypass;
  end

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    rf_we_d = 1'b0;
    rf_rd_d = rf_rd_q;
    rf_wd_d = rf_wd_q;

    if (pipe_req) begin
      rf_we_d = 1'b1;
      rf_rd_d = pipe_rd_i;
      rf_wd_d = pipe_data_i;
    end else if (pop) begin
      rf_we_d = 1'b1;
      rf_rd_d = rd_mem_q[head_q];
      rf_wd_d = data_mem_q[head_q];
    end else if (bypass) begin
      rf_we_d = 1'b1;
      rf_rd_d = mc_rd_i;
      rf_wd_d = mc_data_i;
    end

    if (pop)  head_d = head_q + 1'b1;
    if (push) tail_d = tail_q + 1'b1;

    unique case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase

    if (pop || !not_empty) begin
      starve_d = '0;
    end else if (starve_q != StLimit) begin
      starve_d = starve_q + 1'b1;
    end else begin
      starve_d = starve_q;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      head_q   <= '0;
      tail_q   <= '0;
      count_q  <= '0;
      starve_q <= '0;
      rf_we_q  <= 1'b0;
      rf_rd_q  <= '0;
      rf_wd_q  <= '0;
    end else begin
      head_q   <= head_d;
      tail_q   <= tail_d;
      count_q  <= count_d;
      starve_q <= starve_d;
      rf_we_q  <= rf_we_d;
      rf_rd_q  <= rf_rd_d;
      rf_wd_q  <= rf_wd_d;
    end
  end

  // Storage needs no reset: validity is tracked by head/count alone.
  always_ff @(posedge clk_i) begin
    if (rst_ni && push) begin
      rd_mem_q[tail_q]   <= mc_rd_i;
      data_mem_q[tail_q] <= mc_data_i;
    end
  end

  always_comb begin
    logic [PtrW-1:0] off;
    off       = '0;
    chk_hit_o = 1'b0;
    for (int unsigned j = 0; j < DEPTH; j++) begin
      off = PtrW'(j) - head_q;
      if (({1'b0, off} < count_q) && (rd_mem_q[j] == chk_rd_i)) chk_hit_o = 1'b1;
    end
    if (chk_rd_i == 5'd0) chk_hit_o = 1'b0;
  end

  assign mc_ready_o  = not_full || !rst_ni;
  assign stall_req_o = (starve_q == StLimit);
  assign rf_we_o     = rf_we_q;
  assign rf_rd_o     = rf_rd_q;
  assign rf_wd_o     = rf_wd_q;

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed self-checking bench for wb_port_arbiter (DEPTH=4, STARVE_LIMIT=8).
module tb_wb_port_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        pipe_we;
  logic [4:0]  pipe_rd;
  logic [31:0] pipe_data;
  logic        mc_valid;
  logic        mc_ready;
  logic [4:0]  mc_rd;
  logic [31:0] mc_data;
  logic        rf_we;
  logic [4:0]  rf_rd;
  logic [31:0] rf_wd;
  logic        stall_req;
  logic [4:0]  chk_rd;
  logic        chk_hit;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  wb_port_arbiter #(
    .XLEN(32),
    .DEPTH(4),
    .STARVE_LIMIT(8)
  ) dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .pipe_we_i  (pipe_we),
    .pipe_rd_i  (pipe_rd),
    .pipe_data_i(pipe_data),
    .mc_valid_i (mc_valid),
    .mc_ready_o (mc_ready),
    .mc_rd_i    (mc_rd),
    .mc_data_i  (mc_data),
    .rf_we_o    (rf_we),
    .rf_rd_o    (rf_rd),
    .rf_wd_o    (rf_wd),
    .stall_req_o(stall_req),
    .chk_rd_i   (chk_rd),
    .chk_hit_o  (chk_hit)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic check_wr(input string tag, input logic [4:0] rd, input logic [31:0] wd);
    check({tag, ".we"}, 32'(rf_we), 32'd1);
    check({tag, ".rd"}, 32'(rf_rd), 32'(rd));
    check({tag, ".wd"}, rf_wd, wd);
  endtask

  initial begin
    rst_n = 1'b0; pipe_we = 1'b0; pipe_rd = '0; pipe_data = '0;
    mc_valid = 1'b0; mc_rd = '0; mc_data = '0; chk_rd = 5'd7;
    cyc(); cyc();
    check("rst.rf_we", 32'(rf_we), 32'd0);
    check("rst.rf_rd", 32'(rf_rd), 32'd0);
    check("rst.rf_wd", rf_wd, 32'd0);
    check("rst.stall", 32'(stall_req), 32'd0);
    check("rst.ready", 32'(mc_ready), 32'd1);
    check("rst.hit", 32'(chk_hit), 32'd0);
    rst_n = 1'b1;

    // Pipe-only writes, including the ignored x0 case.
    pipe_we = 1'b1; pipe_rd = 5'd5; pipe_data = 32'h1234;
    cyc();
    check_wr("pipe", 5'd5, 32'h1234);
    pipe_rd = 5'd0; pipe_data = 32'h9999;
    cyc();
    check("pipe_x0.we", 32'(rf_we), 32'd0);
    pipe_we = 1'b0;

    // Single mc result into an idle port.
    mc_valid = 1'b1; mc_rd = 5'd7; mc_data = 32'hCAFE; chk_rd = 5'd7;
    #1;
    check("mc.hit_pre", 32'(chk_hit), 32'd0);
    cyc();
    mc_valid = 1'b0;
`ifdef WB_BYPASS_EN
    check_wr("mc_byp", 5'd7, 32'hCAFE);
    check("mc_byp.hit", 32'(chk_hit), 32'd0);
    cyc();
    check("mc_byp.idle", 32'(rf_we), 32'd0);
`else
    check("mc.we_early", 32'(rf_we), 32'd0);
    check("mc.hit_q", 32'(chk_hit), 32'd1);
    cyc();
    check_wr("mc", 5'd7, 32'hCAFE);
    check("mc.hit_post", 32'(chk_hit), 32'd0);
`endif

    // rd=0 mc result is consumed and dropped.
    mc_valid = 1'b1; mc_rd = 5'd0; mc_data = 32'hDEAD;
    cyc();
    mc_valid = 1'b0;
    check("drop.we0", 32'(rf_we), 32'd0);
    cyc();
    check("drop.we1", 32'(rf_we), 32'd0);

    // Fill under continuous pipe traffic, backpressure, starvation, drain.
    pipe_we = 1'b1; pipe_rd = 5'd3; pipe_data = 32'h3000;
    for (int i = 1; i <= 4; i++) begin
      mc_valid = 1'b1; mc_rd = 5'(i); mc_data = 32'hA0 + 32'(i);
      cyc();
      check_wr("fill.pipe", 5'd3, 32'h3000);
    end
    check("fill.ready0", 32'(mc_ready), 32'd0);
    mc_rd = 5'd5; mc_data = 32'hA5;
    for (int i = 5; i <= 8; i++) cyc();
    check("starve.stall_e8", 32'(stall_req), 32'd0);
    check("starve.ready_e8", 32'(mc_ready), 32'd0);
    cyc();
    check("starve.stall_e9", 32'(stall_req), 32'd1);
    chk_rd = 5'd4;
    #1;
    check("fill.hit4", 32'(chk_hit), 32'd1);
    chk_rd = 5'd5;
    #1;
    check("fill.hit5_held", 32'(chk_hit), 32'd0);
    pipe_we = 1'b0;
    cyc();
    check_wr("drain1", 5'd1, 32'hA1);
    check("drain1.stall", 32'(stall_req), 32'd0);
    check("drain1.ready", 32'(mc_ready), 32'd1);
    cyc();
    mc_valid = 1'b0;
    check_wr("drain2", 5'd2, 32'hA2);
    cyc();
    check_wr("drain3", 5'd3, 32'hA3);
    cyc();
    check_wr("drain4", 5'd4, 32'hA4);
    cyc();
    check_wr("drain5_held", 5'd5, 32'hA5);
    cyc();
    check("drain.empty", 32'(rf_we), 32'd0);

    // Wrap and order: 12 back-to-back pushes, x0 pipe requests ignored throughout.
    pipe_we = 1'b1; pipe_rd = 5'd0; pipe_data = 32'hBAD;
    for (int i = 1; i <= 12; i++) begin
      mc_valid = 1'b1; mc_rd = 5'(((i - 1) % 6) + 1); mc_data = 32'h100 + 32'(i);
      cyc();
`ifdef WB_BYPASS_EN
      check_wr("wrap", 5'(((i - 1) % 6) + 1), 32'h100 + 32'(i));
`else
      if (i == 1) check("wrap.first", 32'(rf_we), 32'd0);
      else check_wr("wrap", 5'(((i - 2) % 6) + 1), 32'h100 + 32'(i - 1));
`endif
    end
    mc_valid = 1'b0; pipe_we = 1'b0;
    cyc();
`ifndef WB_BYPASS_EN
    check_wr("wrap.last", 5'd6, 32'h10C);
    cyc();
`endif
    check("wrap.nodup", 32'(rf_we), 32'd0);

    // Reset mid-operation discards queued entries.
    pipe_we = 1'b1; pipe_rd = 5'd3; pipe_data = 32'h3333;
    mc_valid = 1'b1; mc_rd = 5'd8; mc_data = 32'h88;
    cyc();
    mc_rd = 5'd9; mc_data = 32'h99;
    cyc();
    chk_rd = 5'd8;
    #1;
    check("mid.hit_before", 32'(chk_hit), 32'd1);
    rst_n = 1'b0;
    cyc(); cyc();
    check("mid.rf_we", 32'(rf_we), 32'd0);
    check("mid.stall", 32'(stall_req), 32'd0);
    check("mid.ready", 32'(mc_ready), 32'd1);
    check("mid.hit", 32'(chk_hit), 32'd0);
    rst_n = 1'b1; pipe_we = 1'b0; mc_valid = 1'b0;
    cyc();
    check("mid.post0", 32'(rf_we), 32'd0);
    cyc();
    check("mid.post1", 32'(rf_we), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
